// File: rtl/iot_filter_param.sv
// iot_filter_param: byte-serial IoT data filter.
// Bytes (MSB byte first) are assembled into W = 8*BYTES bit words; every
// completed word is run through the function latched at the start of the
// round of ROUND words (MAX, MIN, AVG, EXT, EXC and optionally PMAX/PMIN).
// Optional feature macro: IOTDF_PEAK_EN enables PMAX/PMIN peak tracking;
// without it function codes 6 and 7 consume words like function 0.
module iot_filter_param #(
    parameter int BYTES = 16,
    parameter int ROUND = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_en,
    input  logic [7:0]         iot_in,
    input  logic [2:0]         fn_sel,
    input  logic [8*BYTES-1:0] lo_th,
    input  logic [8*BYTES-1:0] hi_th,
    output logic               busy,
    output logic               valid,
    output logic [8*BYTES-1:0] iot_out
);

    localparam int W     = 8 * BYTES;
    localparam int LOG_R = $clog2(ROUND);
    localparam int BC_W  = $clog2(BYTES);
    localparam int SUM_W = W + LOG_R;

    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BYTES - 1);
    localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
    localparam logic [LOG_R-1:0] WC_LAST = LOG_R'(ROUND - 1);
    localparam logic [LOG_R-1:0] WC_ONE  = LOG_R'(1);

    localparam logic [2:0] FN_MAX = 3'd1;
    localparam logic [2:0] FN_MIN = 3'd2;
    localparam logic [2:0] FN_AVG = 3'd3;
    localparam logic [2:0] FN_EXT = 3'd4;
    localparam logic [2:0] FN_EXC = 3'd5;
`ifdef IOTDF_PEAK_EN
    localparam logic [2:0] FN_PMAX = 3'd6;
    localparam logic [2:0] FN_PMIN = 3'd7;
`endif

    // The assembler only keeps the first BYTES-1 bytes; the last byte
    // completes the word combinationally.
    logic [W-9:0]     asm_r;
    logic [BC_W-1:0]  byte_cnt_r;
    logic [LOG_R-1:0] word_cnt_r;
    logic [2:0]       fn_r;
    logic [W-1:0]     lo_r;
    logic [W-1:0]     hi_r;
    logic [W-1:0]     max_r;
    logic [W-1:0]     min_r;
    logic [SUM_W-1:0] sum_r;
    logic             busy_r;
    logic             valid_r;
    logic [W-1:0]     out_r;

    logic             accept_s;
    logic             first_byte_s;
    logic             word_done_s;
    logic             last_word_s;
    logic [W-1:0]     word_s;
    logic [W-1:0]     new_max_s;
    logic [W-1:0]     new_min_s;
    logic [SUM_W-1:0] new_sum_s;
    logic             res_valid_s;
    logic [W-1:0]     res_data_s;

`ifdef IOTDF_PEAK_EN
    logic [W-1:0]     peak_r;
    logic             peak_set_r;
    logic             peak_upd_s;
`endif

    assign accept_s     = in_en & ~busy_r;
    assign first_byte_s = accept_s && (byte_cnt_r == {BC_W{1'b0}})
                          && (word_cnt_r == {LOG_R{1'b0}});
    assign word_done_s  = accept_s && (byte_cnt_r == BC_LAST);
    assign last_word_s  = (word_cnt_r == WC_LAST);
    assign word_s       = {asm_r, iot_in};

    // Round aggregates including the current word, and the per-function result.
    always_comb begin
        new_max_s   = word_s;
        new_min_s   = word_s;
        new_sum_s   = {{LOG_R{1'b0}}, word_s};
        res_valid_s = 1'b0;
        res_data_s  = '0;
`ifdef IOTDF_PEAK_EN
        peak_upd_s  = 1'b0;
`endif
        // The first word of a round restarts the aggregates.
        if (word_cnt_r != {LOG_R{1'b0}}) begin
            new_sum_s = sum_r + {{LOG_R{1'b0}}, word_s};
            if (max_r > word_s) begin
                new_max_s = max_r;
            end else begin
                new_max_s = word_s;
            end
            if (min_r < word_s) begin
                new_min_s = min_r;
            end else begin
                new_min_s = word_s;
            end
        end else begin
            new_sum_s = {{LOG_R{1'b0}}, word_s};
            new_max_s = word_s;
            new_min_s = word_s;
        end

        case (fn_r)
            FN_MAX: begin
                res_valid_s = last_word_s;
                res_data_s  = new_max_s;
            end
            FN_MIN: begin
                res_valid_s = last_word_s;
                res_data_s  = new_min_s;
            end
            FN_AVG: begin
                res_valid_s = last_word_s;
                res_data_s  = new_sum_s[SUM_W-1:LOG_R];
            end
            FN_EXT: begin
                res_valid_s = (lo_r < word_s) && (word_s < hi_r);
                res_data_s  = word_s;
            end
            FN_EXC: begin
                res_valid_s = (word_s < lo_r) || (word_s > hi_r);
                res_data_s  = word_s;
            end
`ifdef IOTDF_PEAK_EN
            FN_PMAX: begin
                res_valid_s = last_word_s && (!peak_set_r || (new_max_s > peak_r));
                res_data_s  = new_max_s;
                peak_upd_s  = res_valid_s;
            end
            FN_PMIN: begin
                res_valid_s = last_word_s && (!peak_set_r || (new_min_s < peak_r));
                res_data_s  = new_min_s;
                peak_upd_s  = res_valid_s;
            end
`endif
            default: begin
                res_valid_s = 1'b0;
                res_data_s  = '0;
            end
        endcase
    end

    // Word assembly, byte/word counters, round aggregates and latched controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_r      <= '0;
            byte_cnt_r <= '0;
            word_cnt_r <= '0;
            fn_r       <= 3'd0;
            lo_r       <= '0;
            hi_r       <= '0;
            max_r      <= '0;
            min_r      <= '0;
            sum_r      <= '0;
        end else begin
            if (accept_s) begin
                asm_r <= word_s[W-9:0];
                if (word_done_s) begin
                    byte_cnt_r <= '0;
                end else begin
                    byte_cnt_r <= byte_cnt_r + BC_ONE;
                end
            end
            // ROUND is a power of two, so the word counter wraps by itself.
            if (word_done_s) begin
                word_cnt_r <= word_cnt_r + WC_ONE;
                max_r      <= new_max_s;
                min_r      <= new_min_s;
                sum_r      <= new_sum_s;
            end
            if (first_byte_s) begin
                fn_r <= fn_sel;
                lo_r <= lo_th;
                hi_r <= hi_th;
            end
        end
    end

    // Result cycle: busy for one cycle after each word, result held for that cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            out_r   <= '0;
        end else begin
            busy_r  <= word_done_s;
            valid_r <= word_done_s & res_valid_s;
            if (word_done_s && res_valid_s) begin
                out_r <= res_data_s;
            end else begin
                out_r <= '0;
            end
        end
    end

`ifdef IOTDF_PEAK_EN
    // Peak tracking; a change of function between rounds forgets the peak.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_r     <= '0;
            peak_set_r <= 1'b0;
        end else if (first_byte_s && (fn_sel != fn_r)) begin
            peak_set_r <= 1'b0;
        end else if (word_done_s && peak_upd_s) begin
            peak_r     <= res_data_s;
            peak_set_r <= 1'b1;
        end else begin
            peak_set_r <= peak_set_r;
        end
    end
`endif

    assign busy    = busy_r;
    assign valid   = valid_r;
    assign iot_out = out_r;

endmodule

// File: tb/tb_iot_filter_param.sv
// Directed testbench for iot_filter_param (BYTES=16, ROUND=8).
`timescale 1ns/1ps
module tb_iot_filter_param;

    localparam int BYTES = 16;
    localparam int ROUND = 8;
    localparam int W     = 8 * BYTES;

    logic         clk;
    logic         rst;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic [W-1:0] lo_th;
    logic [W-1:0] hi_th;
    logic         busy;
    logic         valid;
    logic [W-1:0] iot_out;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int nz_cnt   = 0;
    int last_acc = 0;
    bit gap_mode = 1'b0;

    logic [W-1:0] vq[$];
    int           vcyc[$];
    logic [W-1:0] rw[8];

    iot_filter_param #(.BYTES(BYTES), .ROUND(ROUND)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_en   (in_en),
        .iot_in  (iot_in),
        .fn_sel  (fn_sel),
        .lo_th   (lo_th),
        .hi_th   (hi_th),
        .busy    (busy),
        .valid   (valid),
        .iot_out (iot_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, advanced on each active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor on the inactive edge: results, busy cycles, idle-zero rule.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vq.push_back(iot_out);
            vcyc.push_back(cyc);
        end else if (iot_out !== '0) begin
            nz_cnt++;
        end
        if (busy === 1'b1) busy_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        @(posedge clk);
        #1;
        vq.delete();
        vcyc.delete();
        busy_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until an edge where busy is low takes it.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        if (gap_mode) @(posedge clk);
        @(negedge clk);
        in_en  = 1'b1;
        iot_in = b;
        while (busy === 1'b1 && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4) begin
            checks++;
            errors++;
            $display("FAIL busy_stuck: busy=%b held for %0d cycles, required a free cycle", busy, guard);
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        in_en    = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = BYTES - 1; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic send_rw();
        for (int k = 0; k < ROUND; k++) send_word(rw[k]);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        in_en  = 1'b0;
        iot_in = 8'h00;
        fn_sel = 3'd0;
        lo_th  = '0;
        hi_th  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (iot_out !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", iot_out); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_max();
        clear_mon();
        fn_sel = 3'd1;
        for (int k = 0; k < ROUND; k++) rw[k] = {8'(k + 1), 120'h0};
        rw[2] = {8'h80, 120'h0};
        send_word(rw[0]);
        fn_sel = 3'd2;          // must be ignored until the next round
        lo_th  = {W{1'b1}};
        for (int k = 1; k < ROUND; k++) send_word(rw[k]);
        idle(3);
        checks++; if (vq.size() !== 1) begin errors++; $display("FAIL max_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            checks++; if (vq[0] !== {8'h80, 120'h0}) begin errors++; $display("FAIL max_value: got %h want 80<<120", vq[0]); end
            checks++; if (vcyc[0] !== last_acc) begin errors++; $display("FAIL max_latency: got cycle %0d want %0d", vcyc[0], last_acc); end
        end
        checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL max_busy: got %0d want 8", busy_cnt); end
    endtask

    task automatic test_min_ties();
        int mins[8];
        mins = '{9, 5, 7, 5, 8, 12, 5, 6};
        clear_mon();
        fn_sel = 3'd2;
        for (int k = 0; k < ROUND; k++) rw[k] = W'(mins[k]);
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 1) begin errors++; $display("FAIL min_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            checks++; if (vq[0] !== W'(5)) begin errors++; $display("FAIL min_value: got %h want 5", vq[0]); end
        end
        clear_mon();
        fn_sel = 3'd1;
        for (int k = 0; k < ROUND; k++) rw[k] = {16{8'hAA}};
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 1) begin errors++; $display("FAIL maxtie_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            checks++; if (vq[0] !== {16{8'hAA}}) begin errors++; $display("FAIL maxtie_value: got %h want AA..AA", vq[0]); end
        end
    endtask

    task automatic test_avg();
        clear_mon();
        fn_sel = 3'd3;
        for (int k = 0; k < ROUND; k++) rw[k] = {W{1'b1}};
        send_rw();
        for (int k = 0; k < ROUND; k++) rw[k] = W'(k);
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 2) begin errors++; $display("FAIL avg_count: got %0d want 2", vq.size()); end
        if (vq.size() > 1) begin
            checks++; if (vq[0] !== {W{1'b1}}) begin errors++; $display("FAIL avg_ones: got %h want FF..FF", vq[0]); end
            checks++; if (vq[1] !== W'(3)) begin errors++; $display("FAIL avg_small: got %h want 3", vq[1]); end
        end
    endtask

    task automatic test_ext_exc();
        lo_th = {8'h6F, {120{1'b1}}};
        hi_th = {8'hAF, {120{1'b1}}};
        rw[0] = {8'h70, 120'h0};
        rw[1] = lo_th;
        rw[2] = {8'hB0, 120'h0};
        for (int k = 3; k < ROUND; k++) rw[k] = (k % 2 == 1) ? hi_th : lo_th;
        clear_mon();
        fn_sel = 3'd4;
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 1) begin errors++; $display("FAIL ext_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            checks++; if (vq[0] !== {8'h70, 120'h0}) begin errors++; $display("FAIL ext_value: got %h want 70<<120", vq[0]); end
        end
        clear_mon();
        fn_sel = 3'd5;
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 1) begin errors++; $display("FAIL exc_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            checks++; if (vq[0] !== {8'hB0, 120'h0}) begin errors++; $display("FAIL exc_value: got %h want B0<<120", vq[0]); end
        end
        // Inverted thresholds: EXT never fires.
        clear_mon();
        fn_sel = 3'd4;
        lo_th  = W'(10);
        hi_th  = W'(2);
        for (int k = 0; k < ROUND; k++) rw[k] = W'(k);
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 0) begin errors++; $display("FAIL ext_inverted: got %0d outputs want 0", vq.size()); end
        // Equal thresholds: EXC outputs everything except the equal word.
        clear_mon();
        fn_sel = 3'd5;
        lo_th  = W'(5);
        hi_th  = W'(5);
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 7) begin errors++; $display("FAIL exc_equal_count: got %0d want 7", vq.size()); end
        if (vq.size() > 5) begin
            checks++; if (vq[5] !== W'(6)) begin errors++; $display("FAIL exc_equal_skip: got %h want 6", vq[5]); end
        end
    endtask

    task automatic test_none();
        clear_mon();
        fn_sel = 3'd0;
        for (int k = 0; k < ROUND; k++) rw[k] = W'(k + 40);
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 0) begin errors++; $display("FAIL none_count: got %0d want 0", vq.size()); end
        checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL none_busy: got %0d want 8", busy_cnt); end
`ifndef IOTDF_PEAK_EN
        clear_mon();
        fn_sel = 3'd6;
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 0) begin errors++; $display("FAIL pmax_disabled: got %0d outputs want 0", vq.size()); end
`endif
    endtask

`ifdef IOTDF_PEAK_EN
    task automatic test_peak();
        logic [2:0]   pf[8];
        logic [W-1:0] pfirst[8];
        int           pbase[8];
        int           pn[8];
        logic [W-1:0] pexp[8];
        pf     = '{3'd6, 3'd6, 3'd6, 3'd2, 3'd6, 3'd7, 3'd7, 3'd7};
        pfirst = '{{8'h50, 120'h0}, {8'h40, 120'h0}, {8'h60, 120'h0}, {8'h30, 120'h0},
                   {8'h30, 120'h0}, W'(5), W'(5), W'(3)};
        pbase  = '{0, 0, 0, 0, 0, 100, 100, 100};
        pn     = '{1, 0, 1, 1, 1, 1, 0, 1};
        pexp   = '{{8'h50, 120'h0}, '0, {8'h60, 120'h0}, W'(1),
                   {8'h30, 120'h0}, W'(5), '0, W'(3)};
        for (int r = 0; r < 8; r++) begin
            clear_mon();
            fn_sel = pf[r];
            rw[0]  = pfirst[r];
            for (int k = 1; k < ROUND; k++) rw[k] = W'(pbase[r] + k);
            send_rw();
            idle(2);
            checks++; if (vq.size() !== pn[r]) begin errors++; $display("FAIL peak_count_r%0d: got %0d want %0d", r, vq.size(), pn[r]); end
            if (vq.size() > 0 && pn[r] > 0) begin
                checks++; if (vq[0] !== pexp[r]) begin errors++; $display("FAIL peak_value_r%0d: got %h want %h", r, vq[0], pexp[r]); end
            end
        end
    endtask
`endif

    task automatic test_stall();
        clear_mon();
        gap_mode = 1'b1;
        fn_sel   = 3'd3;
        for (int k = 0; k < ROUND; k++) rw[k] = W'(k + 10);
        send_rw();
        gap_mode = 1'b0;
        idle(2);
        checks++; if (vq.size() !== 1) begin errors++; $display("FAIL stall_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            checks++; if (vq[0] !== W'(13)) begin errors++; $display("FAIL stall_avg: got %h want 13", vq[0]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        fn_sel = 3'd1;
        for (int k = 0; k < ROUND; k++) rw[k] = W'(k + 1);
        rw[5] = {8'h11, 120'h0};
        send_rw();
        rw[5] = W'(7);
        rw[7] = {8'h22, 120'h5};
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", vq.size()); end
        if (vq.size() > 1) begin
            checks++; if (vq[0] !== {8'h11, 120'h0}) begin errors++; $display("FAIL b2b_first: got %h want 11<<120", vq[0]); end
            checks++; if (vq[1] !== {8'h22, 120'h5}) begin errors++; $display("FAIL b2b_second: got %h want 22<<120|5", vq[1]); end
        end
        checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL b2b_busy: got %0d want 16", busy_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        fn_sel = 3'd1;
        for (int k = 0; k < 4; k++) send_word({8'hF0, 120'(k)});
        for (int i = 0; i < 5; i++) send_byte(8'hEE);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (iot_out !== '0) begin errors++; $display("FAIL rstmid_out: got %h want 0", iot_out); end
        rst = 1'b0;
        clear_mon();
        fn_sel = 3'd3;
        for (int k = 0; k < ROUND; k++) rw[k] = W'(k + 8);
        send_rw();
        idle(2);
        checks++; if (vq.size() !== 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            checks++; if (vq[0] !== W'(11)) begin errors++; $display("FAIL rstmid_avg: got %h want 11", vq[0]); end
            checks++; if (vcyc[0] !== last_acc) begin errors++; $display("FAIL rstmid_latency: got cycle %0d want %0d", vcyc[0], last_acc); end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_min_ties();
        test_avg();
        test_ext_exc();
        test_none();
`ifdef IOTDF_PEAK_EN
        test_peak();
`endif
        test_stall();
        test_back_to_back();
        test_reset_mid();
        idle(2);
        checks++; if (nz_cnt !== 0) begin errors++; $display("FAIL idle_zero: got %0d nonzero idle cycles want 0", nz_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
